output_slice_wrapper: RTL

OUTPUT_SLICE_WRAPPER -- requirements
Module: output_slice_wrapper

---
 rtl/output_slice_wrapper.sv | 139 +++++++++++++
 1 files changed

// File: rtl/output_slice_wrapper.sv
// Captures a wide word and streams it out one slice at a time on an arbitrated bus.
// A grant timeout backs off for one cycle before requesting again.
module output_slice_wrapper #(
    parameter int SLICE_W     = 8,
    parameter int NSLICE      = 4,
    parameter int GNT_TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [SLICE_W*NSLICE-1:0] in_data,
    output logic                      in_ready,
    input  logic                      gnt,
    input  logic                      out_acc,
    output logic                      request,
    output logic                      out_valid,
    output logic [SLICE_W-1:0]        out_data,
    output logic                      out_last,
    output logic                      out_sent,
    output logic [7:0]                retry_cnt
);

    localparam int IW = $clog2(NSLICE);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_BACKOFF = 2'd2;
    localparam logic [1:0] S_XFER    = 2'd3;

    localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);
    localparam logic [7:0]    TO_MAX   = 8'(GNT_TIMEOUT - 1);

    if (NSLICE < 2 || NSLICE > 16) begin : g_bad_nslice
        $error("NSLICE must be in 2..16");
    end
    if (GNT_TIMEOUT < 1 || GNT_TIMEOUT > 255) begin : g_bad_timeout
        $error("GNT_TIMEOUT must be in 1..255");
    end

    logic [1:0]                state, state_n;
    logic [SLICE_W*NSLICE-1:0] word;
    logic [IW-1:0]             idx, idx_n;
    logic [7:0]                tcnt, tcnt_n;
    logic                      load;
    logic                      retry_bump;
    logic                      is_last;

    logic [SLICE_W-1:0] slices [NSLICE];

    for (genvar k = 0; k < NSLICE; k++) begin : g_slice
        assign slices[k] = word[k*SLICE_W +: SLICE_W];
    end

    assign is_last  = (idx == LAST_IDX);
    assign out_data = slices[idx];

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        tcnt_n     = tcnt;
        load       = 1'b0;
        retry_bump = 1'b0;
        in_ready   = 1'b0;
        request    = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_sent   = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                tcnt_n   = 8'd0;
                if (in_valid) begin
                    load    = 1'b1;
                    idx_n   = '0;
                    state_n = S_REQ;
                end
            end
            S_REQ: begin
                request = 1'b1;
                // A grant arriving on the timeout cycle still wins.
                if (gnt) begin
                    state_n = S_XFER;
                    tcnt_n  = 8'd0;
                end else if (tcnt == TO_MAX) begin
                    state_n    = S_BACKOFF;
                    tcnt_n     = 8'd0;
                    retry_bump = 1'b1;
                end else begin
                    tcnt_n = tcnt + 8'd1;
                end
            end
            S_BACKOFF: begin
                state_n = S_REQ;
            end
            S_XFER: begin
                request   = 1'b1;
                out_valid = 1'b1;
                out_last  = is_last;
                if (out_acc) begin
                    if (is_last) begin
                        out_sent = 1'b1;
                        idx_n    = '0;
                        state_n  = S_IDLE;
                    end else begin
                        idx_n   = idx + 1'b1;
                        state_n = gnt ? S_XFER : S_REQ;
                    end
                end else if (!gnt) begin
                    // Preempted: keep idx so the word resumes where it stopped.
                    state_n = S_REQ;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            word      <= '0;
            idx       <= '0;
            tcnt      <= 8'd0;
            retry_cnt <= 8'd0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            tcnt  <= tcnt_n;
            if (load) begin
                word <= in_data;
            end
            if (retry_bump && retry_cnt != 8'hFF) begin
                retry_cnt <= retry_cnt + 8'd1;
            end
        end
    end

endmodule
